// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed loading, all-zero recovery
// and measurement of the step count between returns to the active seed.
module lfsr_gen #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] FIB_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] GAL_TAPS = 8'h71,
  parameter logic [WIDTH-1:0] SEED     = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH:0]   period_len
);

  logic [WIDTH-1:0] s_reg, s_next;
  logic [WIDTH-1:0] seed_reg, seed_next;
  logic [WIDTH:0]   cnt_reg, cnt_next, cnt_inc;
  logic [WIDTH:0]   period_reg, period_next;
  logic             wrap_reg, wrap_next;
  logic             lockup_reg, lockup_next;
  logic [WIDTH-1:0] fib_next, gal_next, step_val, load_val;

  assign fib_next = {s_reg[WIDTH-2:0], ^(s_reg & FIB_TAPS)};

  // Galois form: shift left, fold the polynomial in when the MSB falls out.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_gal
      if (gi == 0) begin : g_lsb
        assign gal_next[gi] = s_reg[WIDTH-1] & GAL_TAPS[gi];
      end else begin : g_bit
        assign gal_next[gi] = s_reg[gi-1] ^ (s_reg[WIDTH-1] & GAL_TAPS[gi]);
      end
    end
  endgenerate

  always_comb begin
    s_next      = s_reg;
    seed_next   = seed_reg;
    cnt_next    = cnt_reg;
    period_next = period_reg;
    wrap_next   = 1'b0;
    lockup_next = 1'b0;
    step_val    = mode ? gal_next : fib_next;
    // Counter sticks at all-ones so an absurdly long period never aliases.
    cnt_inc     = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
    load_val    = (seed_in != '0) ? seed_in : SEED;

    if (load) begin
      s_next    = load_val;
      seed_next = load_val;
      cnt_next  = '0;
    end else if (en) begin
      if (s_reg == '0) begin
        s_next      = seed_reg;
        cnt_next    = '0;
        lockup_next = 1'b1;
      end else begin
        s_next   = step_val;
        cnt_next = cnt_inc;
        if (step_val == seed_reg) begin
          wrap_next   = 1'b1;
          period_next = cnt_inc;
          cnt_next    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_reg      <= SEED;
      seed_reg   <= SEED;
      cnt_reg    <= '0;
      period_reg <= '0;
      wrap_reg   <= 1'b0;
      lockup_reg <= 1'b0;
    end else begin
      s_reg      <= s_next;
      seed_reg   <= seed_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      wrap_reg   <= wrap_next;
      lockup_reg <= lockup_next;
    end
  end

  assign lfsr_out   = s_reg;
  assign bit_out    = s_reg[WIDTH-1];
  assign wrap       = wrap_reg;
  assign lockup     = lockup_reg;
  assign period_len = period_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 8-bit instance checked cycle by cycle against
// a scoreboard model, plus a 16-bit instance run for one full period.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit default instance
  logic       reset, en, mode, load;
  logic [7:0] seed_in;
  logic [7:0] lfsr8;
  logic       bit8, wrap8, lock8;
  logic [8:0] plen8;

  // 16-bit instance
  logic        r16, en16, mode16, load16;
  logic [15:0] seed16;
  logic [15:0] lfsr16;
  logic        bit16, wrap16, lock16;
  logic [16:0] plen16;

  lfsr_gen dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .seed_in(seed_in), .lfsr_out(lfsr8), .bit_out(bit8), .wrap(wrap8),
    .lockup(lock8), .period_len(plen8)
  );

  lfsr_gen #(.WIDTH(16), .FIB_TAPS(16'hB400), .GAL_TAPS(16'h002D), .SEED(16'hACE1)) dut16 (
    .clk(clk), .reset(r16), .en(en16), .mode(mode16), .load(load16),
    .seed_in(seed16), .lfsr_out(lfsr16), .bit_out(bit16), .wrap(wrap16),
    .lockup(lock16), .period_len(plen16)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] s;
    logic       b;
    logic       w;
    logic       l;
    logic [8:0] p;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] m_s, m_seed;
  logic [8:0] m_cnt, m_plen;

  function automatic logic [7:0] fib(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [7:0] gal(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h71 : 8'h00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Drive one cycle, predict the outcome, compare after the edge.
  task automatic cycle(input logic rn, input logic e, input logic m,
                       input logic ld, input logic [7:0] si);
    exp_t ex, got;
    logic [7:0] nxt;
    reset = rn; en = e; mode = m; load = ld; seed_in = si;
    ex.w = 1'b0;
    ex.l = 1'b0;
    if (!rn) begin
      m_s = 8'h01; m_seed = 8'h01; m_cnt = '0; m_plen = '0;
    end else if (ld) begin
      m_s = (si != 8'h00) ? si : 8'h01;
      m_seed = m_s;
      m_cnt = '0;
    end else if (e && m_s == 8'h00) begin
      m_s = m_seed; m_cnt = '0; ex.l = 1'b1;
    end else if (e) begin
      nxt = m ? gal(m_s) : fib(m_s);
      if (m_cnt != 9'h1FF) m_cnt = m_cnt + 9'd1;
      m_s = nxt;
      if (nxt == m_seed) begin
        ex.w = 1'b1; m_plen = m_cnt; m_cnt = '0;
      end
    end
    ex.s = m_s;
    ex.b = m_s[7];
    ex.p = m_plen;
    sb_q.push_back(ex);
    @(posedge clk); #1;
    got = {lfsr8, bit8, wrap8, lock8, plen8};
    ex = sb_q.pop_front();
    chk("scoreboard", 32'(got), 32'(ex));
  endtask

  // Step until wrap; n = steps taken (0 if no wrap within bound).
  task automatic run_to_wrap(input logic m, input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      cycle(1'b1, 1'b1, m, 1'b0, 8'h00);
      if (wrap8 === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] fib_exp [4];
    logic [7:0] gal_exp [8];
    logic [7:0] hold_val;
    int n;
    fib_exp = '{8'h02, 8'h04, 8'h08, 8'h11};
    gal_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h71};
    reset = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; seed_in = 8'h00;
    r16 = 1'b0; en16 = 1'b0; mode16 = 1'b0; load16 = 1'b0; seed16 = 16'h0000;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset_out", 32'(lfsr8), 32'h01);
    chk("reset_plen", 32'(plen8), 32'h0);
    chk("reset_cnt", 32'(dut8.cnt_reg), 32'h0);

    // Fibonacci sequence and period
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("fib_seq", 32'(lfsr8), 32'(fib_exp[i]));
    end
    run_to_wrap(1'b0, 300, n);
    chk("fib_wrap_step", n + 4, 255);
    chk("fib_period", 32'(plen8), 32'd255);
    chk("fib_wrap_state", 32'(lfsr8), 32'h01);

    // Galois sequence and period
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("gal_seq", 32'(lfsr8), 32'(gal_exp[i]));
    end
    run_to_wrap(1'b1, 300, n);
    chk("gal_wrap_step", n + 8, 255);
    chk("gal_period", 32'(plen8), 32'd255);

    // Seed loading, load beats en
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
    chk("load_a5", 32'(lfsr8), 32'hA5);
    run_to_wrap(1'b0, 300, n);
    chk("a5_wrap_step", n, 255);
    chk("a5_wrap_state", 32'(lfsr8), 32'hA5);
    chk("a5_period", 32'(plen8), 32'd255);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("load_zero", 32'(lfsr8), 32'h01);

    // Lock-up recovery from a deposited all-zero state
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    dut8.s_reg = 8'h00;
    m_s = 8'h00;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("lockup_pulse", 32'(lock8), 32'h1);
    chk("lockup_state", 32'(lfsr8), 32'h01);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("lockup_clear", 32'(lock8), 32'h0);
    chk("resume", 32'(lfsr8), 32'h02);

    // Hold for three cycles
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    hold_val = m_s;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("hold_state", 32'(lfsr8), 32'(hold_val));
      chk("hold_pulses", 32'({wrap8, lock8}), 32'h0);
    end
    chk("pre_reset_plen", 32'(plen8), 32'd255);

    // Reset mid-period wins over en and load
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    chk("midreset_out", 32'(lfsr8), 32'h01);
    chk("midreset_plen", 32'(plen8), 32'h0);
    chk("midreset_cnt", 32'(dut8.cnt_reg), 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // 16-bit Fibonacci full period
    r16 = 1'b0;
    @(posedge clk); #1;
    chk("w16_reset_out", 32'(lfsr16), 32'hACE1);
    chk("w16_reset_plen", 32'(plen16), 32'h0);
    r16 = 1'b1; en16 = 1'b1;
    n = 0;
    for (int i = 1; i <= 70000; i++) begin
      @(posedge clk); #1;
      if (wrap16 === 1'b1) begin
        n = i;
        break;
      end
    end
    en16 = 1'b0;
    chk("w16_wrap_step", n, 65535);
    chk("w16_period", 32'(plen16), 32'd65535);
    chk("w16_wrap_state", 32'(lfsr16), 32'hACE1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised linear-feedback shift register that generalises the fixed 8-bit LFSR to any width, with runtime selection of Fibonacci or Galois form. It adds step enable, seed loading, all-zero lock-up recovery and hardware period measurement. It serves as the pseudo-random source for scramblers, BIST pattern generation and test stimulus in the sequential library.

## Interface
- `WIDTH`, default 8: register width, 3..32.
- `FIB_TAPS`, default 8'hB8: Fibonacci tap mask; bit i set means state[i] feeds the XOR.
- `GAL_TAPS`, default 8'h71: Galois polynomial low terms (x^0..x^WIDTH-1); XORed in when the MSB shifts out.
- `SEED`, default 8'h01: reset and fallback seed; must be non-zero.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  advance one step this cycle.
- `mode`  in  1  0 = Fibonacci, 1 = Galois; sampled every step.
- `load`  in  1  load `seed_in` this cycle.
- `seed_in`  in  WIDTH  seed value for `load`.
- `lfsr_out`  out  WIDTH  current register state.
- `bit_out`  out  1  serial output, equal to `lfsr_out[WIDTH-1]`.
- `wrap`  out  1  one-cycle pulse: the state just returned to the active seed.
- `lockup`  out  1  one-cycle pulse: all-zero state detected and recovered.
- `period_len`  out  WIDTH+1  step count of the last completed period.

## Operation
- Registers:
  - state `s`
  - active seed `seed_r`
  - step counter `cnt` (WIDTH+1 bits)
  - outputs `wrap`, `lockup` and `period_len`
- Priority each cycle: reset > load > lock-up recovery > step > hold.
- Reset (`reset`=0 at a clock edge):
  - `s`=SEED, `seed_r`=SEED, `cnt`=0.
  - `wrap`=0, `lockup`=0, `period_len`=0.
- Load (`load`=1):
  - If `seed_in`≠0, `s` and `seed_r` take `seed_in`; if `seed_in`=0, both take SEED.
  - `cnt` is cleared, `wrap` and `lockup` are 0, `period_len` is held.
  - `en` is ignored that cycle.
- Lock-up (`s`=0 with `en`=1 and `load`=0):
  - `s`=`seed_r`, `cnt`=0, `lockup`=1.
  - No step occurs and `wrap`=0.
  - The all-zero state is reachable only through mid-period mask changes in derived variants; the check stays in the design regardless.
- Fibonacci step (`mode`=0): fb = XOR-reduce(`s` & FIB_TAPS); next `s` = {`s`[WIDTH-2:0], fb}.
- Galois step (`mode`=1): next `s` = {`s`[WIDTH-2:0], 0}, XORed with GAL_TAPS when `s`[WIDTH-1]=1.
- On each step:
  - `cnt` is incremented.
  - If next `s` equals `seed_r`: `wrap`=1, `period_len`=`cnt`+1, `cnt`=0.
- Hold (`en`=0): all state is held and `wrap`/`lockup` are 0.
- Changing `mode` mid-period is legal: the step uses the new form and `cnt` continues counting. `period_len` then reflects the mixed sequence.
- `cnt` saturates at 2^(WIDTH+1)-1 and cannot wrap.

## Timing
- All outputs are registered; `bit_out` is a combinational tap of the `s` register.
- Step latency is 1: the state advanced at edge N appears on `lfsr_out` after edge N.
- `load` takes effect after the same edge; the next `en` step starts from the loaded seed.
- `wrap` and `lockup` are high for exactly one cycle after the edge that caused them.
- Reset mid-operation discards the sequence and `period_len` on the next edge, regardless of `en` or `load`.
- Simultaneous `load` and `en`: the load wins and no step occurs.
- Sustained `en`=1 from reset with maximal taps gives a `wrap` every 2^WIDTH-1 cycles.

## Test plan
- Fibonacci sequence check. Reset, `mode`=0, `en`=1, defaults.
  - Required: `lfsr_out` = 01, 02, 04, 08, 11 on successive cycles.
  - Required: first `wrap` on step 255, with `period_len`=255.
- Galois sequence check. Reset, `mode`=1, `en`=1.
  - Required: `lfsr_out` = 01, 02, 04, 08, 10, 20, 40, 80, 71.
  - Required: `wrap` after 255 steps, with `period_len`=255.
- Seed loading. `load`=1 with `seed_in`=8'hA5 while `en`=1.
  - Required: the next `lfsr_out` is A5 (no step), and `wrap` fires when A5 recurs 255 steps later.
  - Then `load` with `seed_in`=0. Required: `lfsr_out`=01.
- Lock-up recovery. Force `s`=0 (bench hierarchy deposit), `en`=1.
  - Required: one `lockup` pulse, then `lfsr_out`=`seed_r`, and the sequence resumes.
- Hold and reset mid-run. Toggle `en` low for 3 cycles mid-run.
  - Required: `lfsr_out` frozen and no pulses.
  - Assert `reset`=0 mid-period. Required: after that edge, `lfsr_out`=01, `period_len`=0 and `cnt`=0.
- Width generalisation. WIDTH=16, FIB_TAPS=16'hB400, SEED=16'hACE1, Fibonacci mode.
  - Required: `wrap` after 65535 steps, with `period_len`=65535.
